// File: rtl/ascii_arry_to_ascii_in_packer.sv
// rtl/ascii_arry_to_ascii_in_packer.sv - packs a 7-bit character stream into the flat ascii_IN bus
// A frame closes on char_last or a full bus, then is held until frame_ack.
module ascii_arry_to_ascii_in_packer #(
   parameter int                CHAR_W    = 7,
   parameter int                MAX_CHARS = 146,
   parameter int                BUS_W     = 1023,
   parameter logic [CHAR_W-1:0] PAD_CHAR  = 7'h00,
   parameter int                CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CHAR_W-1:0] char_in,
   input  logic              char_valid,
   input  logic              char_last,
   output logic              char_ready,
   input  logic              abort,
   output logic [BUS_W-1:0]  ascii_IN,
   output logic [CNT_W-1:0]  char_count,
   output logic              frame_valid,
   input  logic              frame_ack
);

   localparam int                DATA_W   = CHAR_W * MAX_CHARS;
   localparam logic [DATA_W-1:0] PAD_FILL = {MAX_CHARS{PAD_CHAR}};

   typedef enum logic {COLLECT, HOLD} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] slots_q, slots_d;
   logic [CNT_W-1:0]  char_count_q, char_count_d;
   logic              xfer;

   assign char_ready  = (state_q == COLLECT);
   assign frame_valid = (state_q == HOLD);
   assign char_count  = char_count_q;
   assign xfer        = char_valid && char_ready;

   always_comb begin
      state_d      = state_q;
      slots_d      = slots_q;
      char_count_d = char_count_q;
      case (state_q)
         COLLECT: begin
            if (abort) begin
               slots_d      = PAD_FILL;
               char_count_d = '0;
            end else if (xfer) begin
               // Constant-index slot decode keeps the write a plain mux per slot.
               for (int i = 0; i < MAX_CHARS; i++) begin
                  if (char_count_q == CNT_W'(i)) begin
                     slots_d[i*CHAR_W +: CHAR_W] = char_in;
                  end
               end
               char_count_d = char_count_q + 1'b1;
               if (char_last || (char_count_q == CNT_W'(MAX_CHARS - 1))) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (frame_ack) begin
               state_d      = COLLECT;
               slots_d      = PAD_FILL;
               char_count_d = '0;
            end
         end
         default: begin
            state_d      = COLLECT;
            slots_d      = PAD_FILL;
            char_count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= COLLECT;
         slots_q      <= PAD_FILL;
         char_count_q <= '0;
      end else begin
         state_q      <= state_d;
         slots_q      <= slots_d;
         char_count_q <= char_count_d;
      end
   end

   // Bits above the last slot are tied low.
   generate
      if (BUS_W > DATA_W) begin : g_pad_bus
         assign ascii_IN = {{(BUS_W - DATA_W){1'b0}}, slots_q};
      end else begin : g_exact_bus
         assign ascii_IN = slots_q[BUS_W-1:0];
      end
   endgenerate

endmodule
